// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Brief    : Direct-mapped, write-back / write-allocate data cache controller
//            with a single outstanding line request toward memory.
// Revision : 1.0
// ============================================================================
module dcache_ctrl #(
    parameter int LINES = 64,
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               cpu_addr,
    input  logic                      cpu_re,
    input  logic [3:0]                cpu_we,
    input  logic [31:0]               cpu_din,
    output logic [31:0]               cpu_dout,
    output logic                      stall,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_rw,
    output logic [29-$clog2(WORDS):0] mem_req_addr,
    output logic [WORDS*32-1:0]       mem_req_data,
    input  logic                      mem_resp_valid,
    input  logic [WORDS*32-1:0]       mem_resp_data
);
    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 30 - OFF_W - IDX_W;
    localparam int LINE_W = WORDS * 32;
    localparam int LSB_W  = $clog2(LINE_W);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_WB_REQ  = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_FILL    = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [29:0]        addr_q, addr_d;     // word address, cpu_addr[31:2]
    logic [3:0]         we_q, we_d;
    logic [31:0]        din_q, din_d;
    logic [31:0]        dout_q, dout_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;

    logic [LINE_W-1:0]  data_mem [LINES];
    logic [TAG_W-1:0]   tag_mem  [LINES];

    logic               data_we;
    logic [LINE_W-1:0]  data_wdata;
    logic               tag_we;
    logic               w_complete;

    logic [IDX_W-1:0]   w_idx;
    logic [OFF_W-1:0]   w_off;
    logic [TAG_W-1:0]   w_tag;
    logic [TAG_W-1:0]   w_old_tag;
    logic [LINE_W-1:0]  w_line;
    logic [LSB_W-1:0]   w_word_lsb;
    logic [31:0]        w_word;
    logic [31:0]        w_mask32;
    logic [LINE_W-1:0]  w_mask;
    logic [LINE_W-1:0]  w_merged;
    logic               w_hit;
    logic               w_unused_addr;

    assign w_unused_addr = ^cpu_addr[1:0];

    assign w_idx      = addr_q[OFF_W +: IDX_W];
    assign w_off      = addr_q[OFF_W-1:0];
    assign w_tag      = addr_q[29 -: TAG_W];
    assign w_old_tag  = tag_mem[w_idx];
    assign w_line     = data_mem[w_idx];
    assign w_word_lsb = {w_off, 5'd0};
    assign w_word     = w_line[w_word_lsb +: 32];
    assign w_hit      = valid_q[w_idx] && (w_old_tag == w_tag);

    // Byte-lane merge of the latched write into the addressed word of the line.
    assign w_mask32 = {{8{we_q[3]}}, {8{we_q[2]}}, {8{we_q[1]}}, {8{we_q[0]}}};
    assign w_mask   = {{(LINE_W-32){1'b0}}, w_mask32} << w_word_lsb;
    assign w_merged = (w_line & ~w_mask) | ({WORDS{din_q}} & w_mask);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        we_d          = we_q;
        din_d         = din_q;
        dout_d        = dout_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        w_complete    = 1'b0;
        stall         = 1'b0;
        cpu_dout      = dout_q;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = addr_q[29:OFF_W];
        mem_req_data  = w_line;
        data_we       = 1'b0;
        data_wdata    = w_merged;
        tag_we        = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_LOOKUP: begin
                if (w_hit) begin
                    w_complete = 1'b1;
                end else begin
                    stall   = 1'b1;
                    state_d = (valid_q[w_idx] && dirty_q[w_idx]) ? S_WB_REQ : S_RD_REQ;
                end
            end
            S_WB_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {w_old_tag, w_idx};
                if (mem_req_ready) state_d = S_RD_REQ;
            end
            S_RD_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                stall = 1'b1;
                if (mem_resp_valid) begin
                    data_we        = 1'b1;
                    data_wdata     = mem_resp_data;
                    tag_we         = 1'b1;
                    valid_d[w_idx] = 1'b1;
                    dirty_d[w_idx] = 1'b0;
                    state_d        = S_FILL;
                end
            end
            S_FILL: w_complete = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // FILL finishes exactly like a LOOKUP hit, since the line is now resident.
        if (w_complete) begin
            state_d = S_IDLE;
            if (|we_q) begin
                data_we        = 1'b1;
                dirty_d[w_idx] = 1'b1;
            end else begin
                cpu_dout = w_word;
                dout_d   = w_word;
            end
        end

        if (!stall && (cpu_re || (|cpu_we))) begin
            state_d = S_LOOKUP;
            addr_d  = cpu_addr[31:2];
            we_d    = cpu_we;
            din_d   = cpu_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && data_we) data_mem[w_idx] <= data_wdata;
        if (!reset && tag_we)  tag_mem[w_idx]  <= w_tag;
    end

endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter LINES, default 64, number of direct-mapped lines (power of 2).
REQ-002 Parameter WORDS, default 4, 32-bit words per line (line = 128 bits).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 cpu_addr  input  32  byte address from core; bits [1:0] ignored.
REQ-006 cpu_re  input  1  read request.
REQ-007 cpu_we  input  4  byte write enables; nonzero = write request, overrides cpu_re.
REQ-008 cpu_din  input  32  write data, byte lanes per cpu_we.
REQ-009 cpu_dout  output  32  read data for the accepted request.
REQ-010 stall  output  1  high while the accepted request is not complete.
REQ-011 mem_req_valid  output  1  memory request valid.
REQ-012 mem_req_ready  input  1  memory accepts request when high with valid.
REQ-013 mem_req_rw  output  1  1 = line write, 0 = line read.
REQ-014 mem_req_addr  output  28  line address (byte address [31:4]).
REQ-015 mem_req_data  output  128  write line data, valid with mem_req_rw=1.
REQ-016 mem_resp_valid  input  1  read line returned, one-cycle pulse.
REQ-017 mem_resp_data  input  128  returned line.

Function
REQ-018 Address split: offset [3:2], index [9:4], tag [31:10] (22 bits) at defaults.
REQ-019 Per line: valid bit, dirty bit, 22-bit tag, 128-bit data; write-back, write-allocate.
REQ-020 Request accepted at rising edge where stall=0 and (cpu_re or cpu_we!=0); addr, we, din latched.
REQ-021 While stall=1 cpu_* inputs ignored; no new request accepted.
REQ-022 States: IDLE, LOOKUP, WB_REQ, RD_REQ, RD_WAIT, FILL.
REQ-023 IDLE->LOOKUP on accept; LOOKUP compares latched tag vs stored tag and valid in the cycle after accept.
REQ-024 Read hit: cpu_dout = selected word, stall=0 in that cycle (1-cycle latency); accept of next request permitted same edge.
REQ-025 Write hit: bytes with cpu_we set merged into word at edge ending LOOKUP, dirty<=1, stall=0.
REQ-026 Miss: stall=1 combinationally in LOOKUP cycle; to WB_REQ if valid&dirty, else RD_REQ.
REQ-027 WB_REQ: mem_req_valid=1, rw=1, addr={old tag,index}, data=old line; leave to RD_REQ on valid&ready edge.
REQ-028 RD_REQ: mem_req_valid=1, rw=0, addr=latched [31:4]; to RD_WAIT on valid&ready edge.
REQ-029 mem_req_* outputs stable while valid=1 and ready=0.
REQ-030 RD_WAIT: on mem_resp_valid write line, tag, valid=1, dirty=0; to FILL.
REQ-031 FILL: behaves as LOOKUP (guaranteed hit); read returns word with stall=0; write merges and sets dirty; then IDLE or LOOKUP on new accept.
REQ-032 Miss total latency with ready immediate, response N cycles after read accept: stall high LOOKUP + (WB 1) + RD 1 + N + 0 in FILL.
REQ-033 cpu_dout holds last returned word when stall=0 and no hit; value don't-care while stall=1.
REQ-034 mem_resp_valid outside RD_WAIT ignored.
REQ-035 cpu_re=0 and cpu_we=0 with stall=0: no state change, remain IDLE.

Reset
REQ-036 On reset: state IDLE, all valid and dirty bits 0, stall=0, mem_req_valid=0, cpu_dout=0.
REQ-037 Reset mid-miss aborts transaction; outstanding memory response after reset ignored; data array need not clear.
REQ-038 First request after reset is always a miss.

Verification
REQ-039 After reset, read 0x0000_1004; memory returns line 0x44443333_22221111_0000AAAA_BBBBCCCC -> one RD request addr 0x0000100, stall high until FILL, cpu_dout=0x0000AAAA.
REQ-040 Then read 0x0000_1008 -> no mem request, cpu_dout=0x22221111 next cycle, stall=0.
REQ-041 Write 0x0000_1000 din=0xDEADBEEF we=0011 -> hit, no mem traffic; read back =0xBBBBBEEF.
REQ-042 Read 0x0000_1400 (same index 0, different tag) -> WB request rw=1 addr 0x0000100 data with word0=0xBBBBBEEF, then RD addr 0x0000140.
REQ-043 Hold mem_req_ready=0 for 5 cycles during WB_REQ -> mem_req_* stable, stall=1 throughout.
REQ-044 Assert reset during RD_WAIT, then pulse mem_resp_valid -> IDLE, stall=0, next read of same address misses.
